// File: rtl/svc_rv_btb_pkg.sv
// Shared types and helpers for the direct-mapped BTB and related predictors.
// Holds the 2-bit direction counter encoding and saturating arithmetic.
package svc_rv_btb_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'd0;
    localparam cnt_t CNT_WNT = 2'd1;
    localparam cnt_t CNT_WT  = 2'd2;
    localparam cnt_t CNT_ST  = 2'd3;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == CNT_ST) ? CNT_ST : cnt_t'(c + 2'd1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t c);
        return (c == CNT_SNT) ? CNT_SNT : cnt_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/svc_rv_btb_ctr.sv
// 2-bit saturating direction counter next-state logic (purely combinational).
// Shared with other predictors that keep per-entry direction history.
module svc_rv_btb_ctr
    import svc_rv_btb_pkg::*;
(
    input  cnt_t cnt_i,
    input  logic taken_i,
    output cnt_t cnt_o
);

    assign cnt_o = taken_i ? sat_inc(cnt_i) : sat_dec(cnt_i);

endmodule

// File: rtl/svc_rv_btb.sv
// Direct-mapped branch target buffer: registered lookup aligned with the imem
// read, trained from EX with resolved control-flow outcomes.
module svc_rv_btb
    import svc_rv_btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            lookup_en,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,

    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_uncond,

    input  logic            inv_all
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        cnt_t             cnt;
    } btb_entry_t;

    // Only valid bits are reset so the payload can live in distributed RAM.
    logic [ENTRIES-1:0] valid_q;
    btb_entry_t         mem_q [ENTRIES];

    logic            hit_q;
    logic            taken_q;
    logic [XLEN-1:0] target_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    btb_entry_t       lk_ent;
    logic             lk_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    btb_entry_t       up_ent;
    logic             up_hit;
    cnt_t             up_cnt_nxt;

    logic             wr_en;
    logic             valid_set;
    btb_entry_t       wr_ent;

    logic             unused_pc_bits;

    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign lk_ent = mem_q[lk_idx];
    assign lk_hit = valid_q[lk_idx] && (lk_ent.tag == lk_tag);

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];
    assign up_ent = mem_q[up_idx];
    assign up_hit = valid_q[up_idx] && (up_ent.tag == up_tag);

    svc_rv_btb_ctr u_ctr (
        .cnt_i   (up_ent.cnt),
        .taken_i (upd_taken),
        .cnt_o   (up_cnt_nxt)
    );

    always_comb begin
        wr_en     = 1'b0;
        valid_set = 1'b0;
        wr_ent    = up_ent;
        // inv_all wins: a same-cycle update is dropped entirely.
        if (upd_valid && !inv_all) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (upd_uncond) begin
                    wr_ent.target = upd_target;
                    wr_ent.cnt    = CNT_ST;
                end else begin
                    wr_ent.cnt = up_cnt_nxt;
                    if (upd_taken) wr_ent.target = upd_target;
                end
            end else if (upd_taken) begin
                wr_en         = 1'b1;
                valid_set     = 1'b1;
                wr_ent.tag    = up_tag;
                wr_ent.target = upd_target;
                wr_ent.cnt    = upd_uncond ? CNT_ST : CNT_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (valid_set) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[up_idx] <= wr_ent;
    end

    // Lookup reads pre-edge contents; no bypass from a concurrent update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q    <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (lookup_en) begin
            hit_q    <= lk_hit;
            taken_q  <= lk_hit && lk_ent.cnt[1];
            target_q <= lk_hit ? lk_ent.target : '0;
        end
    end

    assign hit         = hit_q;
    assign pred_taken  = taken_q;
    assign pred_target = target_q;

endmodule

// File: tb/tb_svc_rv_btb.sv
// Directed self-checking bench for svc_rv_btb (ENTRIES=16, XLEN=32).
module tb_svc_rv_btb;

    logic        clk;
    logic        rst_n;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic        hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_uncond;
    logic        inv_all;

    int n_checks = 0;
    int n_fail   = 0;

    svc_rv_btb #(.ENTRIES(16), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_en   (lookup_en),
        .lookup_pc   (lookup_pc),
        .hit         (hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_uncond  (upd_uncond),
        .inv_all     (inv_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic unc);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_uncond = unc;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        lookup_en = 1'b1;
        lookup_pc = pc;
        tick();
        lookup_en = 1'b0;
    endtask

    task automatic chk(input string name, input logic eh, input logic et,
                       input logic [31:0] etg);
        n_checks++;
        if (hit !== eh || pred_taken !== et || pred_target !== etg) begin
            n_fail++;
            $display("FAIL %s: got hit=%b taken=%b target=%h, expected hit=%b taken=%b target=%h",
                     name, hit, pred_taken, pred_target, eh, et, etg);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got hit=%b taken=%b target=%h, expected 0 0 0",
                     hit, pred_taken, pred_target);
        end
        rst_n = 1'b1;
        tick();
        do_lookup(32'h100);
        chk("reset_lookup_miss", 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_cond_alloc();
        do_upd(32'h100, 1'b1, 32'h80, 1'b0);
        do_lookup(32'h100);
        chk("cond_alloc_wt", 1'b1, 1'b1, 32'h80);
    endtask

    task automatic test_counter();
        do_upd(32'h100, 1'b0, 32'h999, 1'b0);
        do_upd(32'h100, 1'b0, 32'h999, 1'b0);
        do_lookup(32'h100);
        chk("cnt_down_to_snt", 1'b1, 1'b0, 32'h80);
        for (int i = 0; i < 4; i++) do_upd(32'h100, 1'b1, 32'h80, 1'b0);
        do_lookup(32'h100);
        chk("cnt_sat_st", 1'b1, 1'b1, 32'h80);
        do_upd(32'h100, 1'b0, 32'h0, 1'b0);
        do_lookup(32'h100);
        chk("cnt_st_minus1", 1'b1, 1'b1, 32'h80);
        do_upd(32'h100, 1'b0, 32'h0, 1'b0);
        do_lookup(32'h100);
        chk("cnt_wnt", 1'b1, 1'b0, 32'h80);
    endtask

    task automatic test_alias();
        do_upd(32'h100, 1'b1, 32'h200, 1'b1);
        do_lookup(32'h100);
        chk("jal_hit_update", 1'b1, 1'b1, 32'h200);
        do_upd(32'h140, 1'b1, 32'h300, 1'b0);
        do_lookup(32'h100);
        chk("alias_evicted", 1'b0, 1'b0, 32'h0);
        do_lookup(32'h140);
        chk("alias_new", 1'b1, 1'b1, 32'h300);
        do_upd(32'h140, 1'b0, 32'h0, 1'b0);
        do_upd(32'h140, 1'b0, 32'h0, 1'b0);
        do_upd(32'h140, 1'b1, 32'h0, 1'b1);
        do_lookup(32'h140);
        chk("jal_forces_st", 1'b1, 1'b1, 32'h0);
    endtask

    task automatic test_back_to_back();
        upd_valid  = 1'b1;
        upd_pc     = 32'h104;
        upd_taken  = 1'b1;
        upd_target = 32'h400;
        upd_uncond = 1'b0;
        lookup_en  = 1'b1;
        lookup_pc  = 32'h104;
        tick();
        upd_valid  = 1'b0;
        chk("same_cycle_old", 1'b0, 1'b0, 32'h0);
        tick();
        lookup_en  = 1'b0;
        chk("next_cycle_new", 1'b1, 1'b1, 32'h400);
        do_upd(32'h108, 1'b0, 32'h500, 1'b0);
        lookup_pc = 32'h140;
        tick();
        tick();
        chk("hold_en_low", 1'b1, 1'b1, 32'h400);
        do_lookup(32'h108);
        chk("nt_miss_no_alloc", 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_inv_all();
        inv_all    = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h108;
        upd_taken  = 1'b1;
        upd_target = 32'h600;
        upd_uncond = 1'b1;
        lookup_en  = 1'b1;
        lookup_pc  = 32'h104;
        tick();
        inv_all    = 1'b0;
        upd_valid  = 1'b0;
        lookup_en  = 1'b0;
        chk("inv_lookup_pre", 1'b1, 1'b1, 32'h400);
        tick();
        chk("inv_outputs_kept", 1'b1, 1'b1, 32'h400);
        do_lookup(32'h100);
        chk("inv_miss_100", 1'b0, 1'b0, 32'h0);
        do_lookup(32'h104);
        chk("inv_miss_104", 1'b0, 1'b0, 32'h0);
        do_lookup(32'h108);
        chk("inv_miss_108", 1'b0, 1'b0, 32'h0);
        do_lookup(32'h140);
        chk("inv_miss_140", 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_async_reset();
        do_upd(32'h10C, 1'b1, 32'h700, 1'b0);
        do_lookup(32'h10C);
        chk("pre_reset_hit", 1'b1, 1'b1, 32'h700);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        tick();
        do_lookup(32'h10C);
        chk("reset_cleared_valid", 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        lookup_en  = 1'b0;
        lookup_pc  = '0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        upd_uncond = 1'b0;
        inv_all    = 1'b0;
        test_reset();
        test_cond_alloc();
        test_counter();
        test_alias();
        test_back_to_back();
        test_inv_all();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
